// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//
// Groups the handshake and bus signals around alu_op_sequencer. There are four groups:
//   - ld_*   : direct register-file load strobe, index and data
//   - cmd_*  : command channel (valid/ready) with ALU control and register indices
//   - alu_*  : operand/control outputs to the combinational ALU and its result/flags
//   - rsp_*  : response channel (valid/ready) carrying the captured result and flags
//
// Modports:
//   slave  : the sequencer itself
//   master : the environment, i.e. the control path and the ALU
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();

  // Register-file load path
  logic             ld_valid;
  logic [1:0]       ld_idx;
  logic [WIDTH-1:0] ld_data;

  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [3:0]       cmd_select;
  logic             cmd_carry_in;
  logic [1:0]       cmd_src_a;
  logic [1:0]       cmd_src_b;
  logic [1:0]       cmd_dst;
  logic             cmd_wr_en;

  // ALU side
  logic             alu_mode;
  logic [3:0]       alu_select;
  logic             alu_carry_in;
  logic [WIDTH-1:0] alu_in_a;
  logic [WIDTH-1:0] alu_in_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry_out;
  logic             alu_compare;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_compare;

  modport slave (
    input  ld_valid, ld_idx, ld_data,
    input  cmd_valid, cmd_mode, cmd_select, cmd_carry_in,
    input  cmd_src_a, cmd_src_b, cmd_dst, cmd_wr_en,
    output cmd_ready,
    output alu_mode, alu_select, alu_carry_in, alu_in_a, alu_in_b,
    input  alu_out, alu_carry_out, alu_compare,
    output rsp_valid, rsp_data, rsp_carry, rsp_compare,
    input  rsp_ready
  );

  modport master (
    output ld_valid, ld_idx, ld_data,
    output cmd_valid, cmd_mode, cmd_select, cmd_carry_in,
    output cmd_src_a, cmd_src_b, cmd_dst, cmd_wr_en,
    input  cmd_ready,
    input  alu_mode, alu_select, alu_carry_in, alu_in_a, alu_in_b,
    output alu_out, alu_carry_out, alu_compare,
    input  rsp_valid, rsp_data, rsp_carry, rsp_compare,
    output rsp_ready
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Multi-cycle command front end for a combinational 16-bit ALU. It holds a four-entry operand
// register file. Each accepted command reads two registers and presents them, together with the
// requested mode/select/carry, to the ALU for SETTLE cycles. It then captures the result and
// flags, optionally writes the result back, and offers a response until it is consumed.
//
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_op_sequencer_if.slave (ld_*, cmd_*, alu_*, rsp_* groups)
//
// Parameters:
//   WIDTH  : datapath width, must match the ALU operand width
//   SETTLE : cycles the ALU inputs are held before capture, legal range 1..15
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;

  // Latched command fields; mode/select/carry/operands are also the ALU drive registers
  logic             mode_q, mode_d;
  logic [3:0]       select_q, select_d;
  logic             carry_in_q, carry_in_d;
  logic [WIDTH-1:0] in_a_q, in_a_d;
  logic [WIDTH-1:0] in_b_q, in_b_d;
  logic [1:0]       dst_q, dst_d;
  logic             wr_en_q, wr_en_d;

  // Captured response
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_compare_q, rsp_compare_d;

  logic [WIDTH-1:0] regfile_q [4];
  logic [WIDTH-1:0] regfile_d [4];

  logic             cmd_ready;

  // Qualified with rst_n so no command can be seen as accepted while reset is held
  assign cmd_ready = (state_q == StIdle) & rst_n;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    select_d      = select_q;
    carry_in_d    = carry_in_q;
    in_a_d        = in_a_q;
    in_b_d        = in_b_q;
    dst_d         = dst_q;
    wr_en_d       = wr_en_q;
    rsp_data_d    = rsp_data_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_compare_d = rsp_compare_q;
    regfile_d     = regfile_q;

    // The load port is live in every state. The writeback below is assigned later, so it
    // overrides a load to the same index in the same cycle.
    if (bus.ld_valid) begin
      regfile_d[bus.ld_idx] = bus.ld_data;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready) begin
          mode_d     = bus.cmd_mode;
          select_d   = bus.cmd_select;
          carry_in_d = bus.cmd_carry_in;
          dst_d      = bus.cmd_dst;
          wr_en_d    = bus.cmd_wr_en;
          // Operands come from the registered file, so a same-cycle load is not visible
          in_a_d     = regfile_q[bus.cmd_src_a];
          in_b_d     = regfile_q[bus.cmd_src_b];
          cnt_d      = SettleCnt;
          state_d    = StExec;
        end
      end

      StExec: begin
        cnt_d = cnt_q - 4'd1;
        // The last settle cycle: the ALU output has been stable for SETTLE cycles
        if (cnt_q == 4'd1) begin
          rsp_data_d    = bus.alu_out;
          rsp_carry_d   = bus.alu_carry_out;
          rsp_compare_d = bus.alu_compare;
          if (wr_en_q) begin
            regfile_d[dst_q] = bus.alu_out;
          end
          state_d = StResp;
        end
      end

      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      select_q      <= '0;
      carry_in_q    <= 1'b0;
      in_a_q        <= '0;
      in_b_q        <= '0;
      dst_q         <= '0;
      wr_en_q       <= 1'b0;
      rsp_data_q    <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_compare_q <= 1'b0;
      regfile_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      select_q      <= select_d;
      carry_in_q    <= carry_in_d;
      in_a_q        <= in_a_d;
      in_b_q        <= in_b_d;
      dst_q         <= dst_d;
      wr_en_q       <= wr_en_d;
      rsp_data_q    <= rsp_data_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_compare_q <= rsp_compare_d;
      regfile_q     <= regfile_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.alu_mode     = mode_q;
  assign bus.alu_select   = select_q;
  assign bus.alu_carry_in = carry_in_q;
  assign bus.alu_in_a     = in_a_q;
  assign bus.alu_in_b     = in_b_q;
  assign bus.rsp_valid    = (state_q == StResp);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_compare  = rsp_compare_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer with SETTLE = 4. It includes a small ALU model: A+B with
// carry for mode 0 / select 1001, and A^B for mode 1 / select 0110. The compare flag is A == B.
// Expected responses are queued when a command is issued and popped when the response appears.
module tb_alu_op_sequencer;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SETTLE = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             compare;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  rsp_t exp_q[$];

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model
  always_comb begin
    logic [WIDTH:0] sum;
    sum               = '0;
    bus.alu_out       = '0;
    bus.alu_carry_out = 1'b0;
    bus.alu_compare   = (bus.alu_in_a == bus.alu_in_b);
    if (!bus.alu_mode && bus.alu_select == 4'b1001) begin
      sum               = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b} + {{WIDTH{1'b0}},
                          bus.alu_carry_in};
      bus.alu_out       = sum[WIDTH-1:0];
      bus.alu_carry_out = sum[WIDTH];
    end else if (bus.alu_mode && bus.alu_select == 4'b0110) begin
      bus.alu_out = bus.alu_in_a ^ bus.alu_in_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic c, input logic m);
    rsp_t e;
    e.data    = d;
    e.carry   = c;
    e.compare = m;
    exp_q.push_back(e);
  endtask

  task automatic ld(input logic [1:0] idx, input logic [WIDTH-1:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_idx   = idx;
    bus.ld_data  = d;
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  task automatic set_cmd(input logic mode, input logic [3:0] sel, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] dst, input logic wr);
    bus.cmd_mode     = mode;
    bus.cmd_select   = sel;
    bus.cmd_carry_in = 1'b0;
    bus.cmd_src_a    = a;
    bus.cmd_src_b    = b;
    bus.cmd_dst      = dst;
    bus.cmd_wr_en    = wr;
    bus.cmd_valid    = 1'b1;
  endtask

  // Called at the negedge before the accept edge; returns at the negedge after it
  task automatic accept(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_exec", bus.cmd_ready, 0);
    chk("alu_in_a", bus.alu_in_a, ea);
    chk("alu_in_b", bus.alu_in_b, eb);
  endtask

  // start = clock edges already elapsed since the accept edge
  task automatic wait_rsp(input int start);
    int   lat;
    rsp_t e;
    lat = start;
    while (bus.rsp_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, SETTLE);
    chk("rsp_queue", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_data", bus.rsp_data, e.data);
      chk("rsp_carry", bus.rsp_carry, e.carry);
      chk("rsp_compare", bus.rsp_compare, e.compare);
    end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", bus.rsp_valid, 0);
    chk("cmd_ready_after_ack", bus.cmd_ready, 1);
  endtask

  task automatic do_cmd(input logic mode, input logic [3:0] sel, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] dst, input logic wr,
                        input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                        input logic [WIDTH-1:0] ed, input logic ec, input logic em);
    push(ed, ec, em);
    set_cmd(mode, sel, a, b, dst, wr);
    accept(ea, eb);
    wait_rsp(0);
    ack();
  endtask

  // A+B into r2 with a load landing on the writeback edge
  task automatic collide(input logic [1:0] ld_idx, input logic [WIDTH-1:0] ld_data,
                         input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                         input logic [WIDTH-1:0] ed);
    push(ed, 1'b0, 1'b0);
    set_cmd(1'b0, 4'b1001, 2'd0, 2'd1, 2'd2, 1'b1);
    accept(ea, eb);
    repeat (SETTLE - 1) @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_idx   = ld_idx;
    bus.ld_data  = ld_data;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    wait_rsp(SETTLE);
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ld_valid     = 1'b0;
    bus.ld_idx       = '0;
    bus.ld_data      = '0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_mode     = 1'b0;
    bus.cmd_select   = '0;
    bus.cmd_carry_in = 1'b0;
    bus.cmd_src_a    = '0;
    bus.cmd_src_b    = '0;
    bus.cmd_dst      = '0;
    bus.cmd_wr_en    = 1'b0;
    bus.rsp_ready    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_alu_in_a", bus.alu_in_a, 0);
    chk("rst_alu_select", bus.alu_select, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Add with writeback, then read r2 back through r2 + r3 (r3 = 0)
    ld(2'd0, 16'h1234);
    ld(2'd1, 16'h0F0F);
    push(16'h2143, 1'b0, 1'b0);
    set_cmd(1'b0, 4'b1001, 2'd0, 2'd1, 2'd2, 1'b1);
    accept(16'h1234, 16'h0F0F);
    chk("alu_select", bus.alu_select, 4'b1001);
    chk("alu_mode", bus.alu_mode, 0);
    wait_rsp(0);
    ack();
    chk("alu_hold_idle", bus.alu_in_a, 16'h1234);
    do_cmd(1'b0, 4'b1001, 2'd2, 2'd3, 2'd0, 1'b0, 16'h2143, 16'h0000, 16'h2143, 1'b0, 1'b0);

    // XOR without writeback: dst r1 must be unchanged
    do_cmd(1'b1, 4'b0110, 2'd0, 2'd1, 2'd1, 1'b0, 16'h1234, 16'h0F0F, 16'h1D3B, 1'b0, 1'b0);
    do_cmd(1'b0, 4'b1001, 2'd1, 2'd3, 2'd0, 1'b0, 16'h0F0F, 16'h0000, 16'h0F0F, 1'b0, 1'b0);

    // Carry out, dst equal to a source
    ld(2'd0, 16'hFFFF);
    ld(2'd1, 16'h0001);
    do_cmd(1'b0, 4'b1001, 2'd0, 2'd1, 2'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_cmd(1'b0, 4'b1001, 2'd0, 2'd3, 2'd1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // src_a == src_b
    ld(2'd1, 16'h0101);
    do_cmd(1'b0, 4'b1001, 2'd1, 2'd1, 2'd3, 1'b0, 16'h0101, 16'h0101, 16'h0202, 1'b0, 1'b1);

    // Backpressure with a pending command
    push(16'h0202, 1'b0, 1'b1);
    set_cmd(1'b0, 4'b1001, 2'd1, 2'd1, 2'd3, 1'b0);
    accept(16'h0101, 16'h0101);
    wait_rsp(0);
    push(16'h0101, 1'b0, 1'b0);
    set_cmd(1'b1, 4'b0110, 2'd0, 2'd1, 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_data", bus.rsp_data, 16'h0202);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_alu_in_a", bus.alu_in_a, 16'h0101);
    end
    ack();
    chk("bp_not_yet_accepted", bus.alu_in_a, 16'h0101);
    accept(16'h0000, 16'h0101);
    wait_rsp(0);
    ack();

    // Writeback collisions: same index (writeback wins), different index (both land)
    ld(2'd0, 16'h1111);
    collide(2'd2, 16'hAAAA, 16'h1111, 16'h0101, 16'h1212);
    do_cmd(1'b0, 4'b1001, 2'd2, 2'd3, 2'd0, 1'b0, 16'h1212, 16'h0000, 16'h1212, 1'b0, 1'b0);
    collide(2'd3, 16'h5555, 16'h1111, 16'h0101, 16'h1212);
    do_cmd(1'b0, 4'b1001, 2'd2, 2'd3, 2'd0, 1'b0, 16'h1212, 16'h5555, 16'h6767, 1'b0, 1'b0);

    // Reset two cycles into EXEC: in-flight command dropped, regfile cleared
    ld(2'd0, 16'h00FF);
    set_cmd(1'b0, 4'b1001, 2'd0, 2'd1, 2'd3, 1'b1);
    accept(16'h00FF, 16'h0101);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_in_a", bus.alu_in_a, 0);
    chk("mid_rst_alu_in_b", bus.alu_in_b, 0);
    chk("mid_rst_alu_select", bus.alu_select, 0);
    chk("mid_rst_rsp_data", bus.rsp_data, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < int'(SETTLE) + 2; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    chk("mid_rst_no_rsp_pulse", pulses, 0);
    chk("mid_rst_cmd_ready_after", bus.cmd_ready, 1);
    do_cmd(1'b0, 4'b1001, 2'd0, 2'd1, 2'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    do_cmd(1'b0, 4'b1001, 2'd2, 2'd3, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
